ps2_cmd_ctrl: RTL and testbench
===============================

PS2_CMD_CTRL -- requirements
Module: ps2_cmd_ctrl

Interface
REQ-001 Parameter RESP_TIMEOUT, default 2000000, clk cycles allowed for device response after tx completion.
REQ-002 Parameter MAX_RETRY, default 3, resends allowed after first attempt before failure.
REQ-003 clk  input  1  system clock, all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 cmd_valid  input  1  host command byte request.
REQ-006 cmd_data  input  8  host command byte.
REQ-007 cmd_ready  output  1  controller accepts command this cycle.
REQ-008 tx_start  output  1  one-cycle write enable to PS/2 tx unit.
REQ-009 tx_data  output  8  byte for tx unit, valid while tx_start high.
REQ-010 tx_done_tick  input  1  tx unit finished, device ack received.
REQ-011 tx_err  input  1  tx unit aborted (no ack / line fault), one-cycle pulse.
REQ-012 rx_en  output  1  enables PS/2 rx unit.
REQ-013 rx_done_tick  input  1  rx unit delivered byte, one-cycle pulse.
REQ-014 rx_data  input  8  received byte, valid with rx_done_tick.
REQ-015 rx_err  input  1  rx parity/framing error, one-cycle pulse.
REQ-016 key_valid  output  1  one-cycle pulse, key_data holds forwarded device byte.
REQ-017 key_data  output  8  forwarded device byte, held until next key_valid.
REQ-018 resp_ok  output  1  one-cycle pulse, command acknowledged with 0xFA.
REQ-019 resp_fail  output  1  one-cycle pulse, command abandoned after retries.
REQ-020 busy  output  1  high in every state except IDLE.

Function
REQ-021 States: IDLE, SEND, WAIT_TX, WAIT_RESP; all outputs registered.
REQ-022 IDLE: cmd_ready=1, rx_en=1; rx_done_tick -> key_valid next cycle, key_data=rx_data.
REQ-023 IDLE: cmd_valid&cmd_ready -> latch cmd_data, retry_cnt=0, -> SEND.
REQ-024 IDLE simultaneous rx_done_tick and command accept: forward byte and accept command, both.
REQ-025 SEND: rx_en=0, cmd_ready=0, tx_start=1 exactly one cycle, tx_data=latched byte, -> WAIT_TX.
REQ-026 Latency: command accepted at edge N -> tx_start high during cycle N+1.
REQ-027 WAIT_TX: rx_en=0; tx_done_tick -> clear timer, -> WAIT_RESP; tx_err -> RETRY decision.
REQ-028 WAIT_TX has no timeout; tx unit owns its own watchdog.
REQ-029 WAIT_RESP: rx_en=1, timer increments each cycle from 0.
REQ-030 WAIT_RESP rx_done_tick, rx_data=0xFA -> resp_ok pulse, -> IDLE; byte not forwarded.
REQ-031 WAIT_RESP rx_done_tick, rx_data=0xFE -> RETRY decision; byte not forwarded.
REQ-032 WAIT_RESP rx_done_tick, any other byte -> forwarded via key_valid, timer not reset, remain.
REQ-033 WAIT_RESP rx_err, or timer reaching RESP_TIMEOUT-1 -> RETRY decision.
REQ-034 rx_done_tick and timeout same cycle: rx_done_tick wins.
REQ-035 RETRY decision: retry_cnt<MAX_RETRY -> retry_cnt+1, -> SEND; else resp_fail pulse, -> IDLE.
REQ-036 MAX_RETRY=0: first failure yields resp_fail, no resend.
REQ-037 Total tx_start pulses per command never exceed MAX_RETRY+1.
REQ-038 cmd_valid ignored outside IDLE; cmd_data not re-sampled.
REQ-039 Timer width ceil(log2(RESP_TIMEOUT))+1; no wrap before timeout.
REQ-040 rx_done_tick/rx_err in SEND or WAIT_TX ignored, no key_valid.

Reset
REQ-041 reset low: state=IDLE immediately, asynchronously, regardless of state.
REQ-042 Reset values: tx_start=0, tx_data=0x00, rx_en=0, cmd_ready=0, key_valid=0, key_data=0x00, resp_ok=0, resp_fail=0, busy=0, timer=0, retry_cnt=0.
REQ-043 First edge after reset release: rx_en=1, cmd_ready=1.
REQ-044 Reset mid-command: no resp_ok/resp_fail issued; command dropped.

Verification
REQ-045 IDLE, rx_done_tick rx_data=0x1C -> key_valid one cycle later, key_data=0x1C, busy=0.
REQ-046 cmd 0xED accepted -> tx_start next cycle tx_data=0xED; tx_done_tick; rx 0xFA -> resp_ok one pulse, IDLE.
REQ-047 cmd 0xFF, MAX_RETRY=2, device answers 0xFE thrice -> exactly 3 tx_start pulses of 0xFF, then resp_fail.
REQ-048 RESP_TIMEOUT=50, no rx after tx_done_tick -> resend at cycle 50; MAX_RETRY=0 -> resp_fail, no resend.
REQ-049 WAIT_RESP, rx 0x1C then 0xFA -> key_valid with 0x1C, then resp_ok; 0xFA never on key_data.
REQ-050 reset asserted in WAIT_TX -> all outputs at reset values same cycle; release -> IDLE, no resp pulse.

Source files
------------

// File: rtl/ps2_cmd_ctrl.sv
// PS/2 host command controller: sends a command byte through the tx unit, waits for the
// device's 0xFA acknowledge, resends on 0xFE/error/timeout and forwards all other device bytes.
`timescale 1ns/1ps
module ps2_cmd_ctrl #(
    parameter int RESP_TIMEOUT = 2000000,
    parameter int MAX_RETRY    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_data,
    output logic       cmd_ready,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_done_tick,
    input  logic       tx_err,
    output logic       rx_en,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    input  logic       rx_err,
    output logic       key_valid,
    output logic [7:0] key_data,
    output logic       resp_ok,
    output logic       resp_fail,
    output logic       busy
);

    localparam int TW = $clog2(RESP_TIMEOUT) + 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [TW-1:0] TO_LAST   = TW'(RESP_TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [7:0]    BYTE_ACK    = 8'hFA;
    localparam logic [7:0]    BYTE_RESEND = 8'hFE;

    typedef enum logic [1:0] {IDLE, SEND, WAIT_TX, WAIT_RESP} state_t;

    state_t        state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [RW-1:0] retry_cnt, retry_n;
    logic [7:0]    tx_data_n, key_data_n;
    logic          key_valid_n, resp_ok_n, resp_fail_n;
    logic          retry_req, timeout;

    always_comb begin
        state_n     = state;
        timer_n     = timer;
        retry_n     = retry_cnt;
        tx_data_n   = tx_data;
        key_data_n  = key_data;
        key_valid_n = 1'b0;
        resp_ok_n   = 1'b0;
        resp_fail_n = 1'b0;
        retry_req   = 1'b0;
        timeout     = (timer >= TO_LAST);

        case (state)
            IDLE: begin
                if (rx_done_tick) begin
                    key_valid_n = 1'b1;
                    key_data_n  = rx_data;
                end
                if (cmd_valid && cmd_ready) begin
                    tx_data_n = cmd_data;
                    retry_n   = '0;
                    state_n   = SEND;
                end
            end
            SEND: state_n = WAIT_TX;
            WAIT_TX: begin
                if (tx_done_tick) begin
                    timer_n = '0;
                    state_n = WAIT_RESP;
                end else if (tx_err) begin
                    retry_req = 1'b1;
                end
            end
            WAIT_RESP: begin
                // Saturate so a forwarded byte landing on the timeout cycle still times out next cycle
                timer_n = timeout ? timer : timer + TW'(1);
                if (rx_done_tick) begin
                    if (rx_data == BYTE_ACK) begin
                        resp_ok_n = 1'b1;
                        state_n   = IDLE;
                    end else if (rx_data == BYTE_RESEND) begin
                        retry_req = 1'b1;
                    end else begin
                        key_valid_n = 1'b1;
                        key_data_n  = rx_data;
                    end
                end else if (rx_err || timeout) begin
                    retry_req = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        if (retry_req) begin
            if (retry_cnt != RETRY_MAX) begin
                retry_n = retry_cnt + RW'(1);
                state_n = SEND;
            end else begin
                resp_fail_n = 1'b1;
                state_n     = IDLE;
            end
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            timer     <= '0;
            retry_cnt <= '0;
            tx_start  <= 1'b0;
            tx_data   <= 8'h00;
            rx_en     <= 1'b0;
            cmd_ready <= 1'b0;
            key_valid <= 1'b0;
            key_data  <= 8'h00;
            resp_ok   <= 1'b0;
            resp_fail <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            retry_cnt <= retry_n;
            tx_start  <= (state_n == SEND);
            tx_data   <= tx_data_n;
            rx_en     <= (state_n == IDLE) || (state_n == WAIT_RESP);
            cmd_ready <= (state_n == IDLE);
            key_valid <= key_valid_n;
            key_data  <= key_data_n;
            resp_ok   <= resp_ok_n;
            resp_fail <= resp_fail_n;
            busy      <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_ps2_cmd_ctrl.sv
// Directed bench for ps2_cmd_ctrl: two instances share stimulus, one with two retries
// and one with none, both with a 50-cycle response timeout.
`timescale 1ns/1ps
module tb_ps2_cmd_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic       tx_done_tick = 1'b0;
    logic       tx_err = 1'b0;
    logic       rx_done_tick = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_err = 1'b0;

    logic       cmd_ready, tx_start, rx_en, key_valid, resp_ok, resp_fail, busy;
    logic [7:0] tx_data, key_data;
    logic       z_cmd_ready, z_tx_start, z_rx_en, z_key_valid, z_resp_ok, z_resp_fail, z_busy;
    logic [7:0] z_tx_data, z_key_data;

    logic [22:0] out_vec, z_out_vec;
    assign out_vec   = {tx_start, tx_data, rx_en, cmd_ready, key_valid, key_data,
                        resp_ok, resp_fail, busy};
    assign z_out_vec = {z_tx_start, z_tx_data, z_rx_en, z_cmd_ready, z_key_valid, z_key_data,
                        z_resp_ok, z_resp_fail, z_busy};

    int checks = 0;
    int errors = 0;
    int n_tx = 0, n_tx0 = 0, n_resp = 0;
    int base, base0, first_k;

    always #5 clk = ~clk;

    ps2_cmd_ctrl #(.RESP_TIMEOUT(50), .MAX_RETRY(2)) u_dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
        .cmd_ready(cmd_ready), .tx_start(tx_start), .tx_data(tx_data),
        .tx_done_tick(tx_done_tick), .tx_err(tx_err), .rx_en(rx_en),
        .rx_done_tick(rx_done_tick), .rx_data(rx_data), .rx_err(rx_err),
        .key_valid(key_valid), .key_data(key_data), .resp_ok(resp_ok),
        .resp_fail(resp_fail), .busy(busy)
    );

    ps2_cmd_ctrl #(.RESP_TIMEOUT(50), .MAX_RETRY(0)) u_dut0 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
        .cmd_ready(z_cmd_ready), .tx_start(z_tx_start), .tx_data(z_tx_data),
        .tx_done_tick(tx_done_tick), .tx_err(tx_err), .rx_en(z_rx_en),
        .rx_done_tick(rx_done_tick), .rx_data(rx_data), .rx_err(rx_err),
        .key_valid(z_key_valid), .key_data(z_key_data), .resp_ok(z_resp_ok),
        .resp_fail(z_resp_fail), .busy(z_busy)
    );

    always @(negedge clk) begin
        if (tx_start)             n_tx   <= n_tx + 1;
        if (z_tx_start)           n_tx0  <= n_tx0 + 1;
        if (resp_ok || resp_fail) n_resp <= n_resp + 1;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic send_cmd(input logic [7:0] b);
        cmd_data  = b;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic pulse_txdone();
        tx_done_tick = 1'b1;
        tick();
        tx_done_tick = 1'b0;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        rx_data      = b;
        rx_done_tick = 1'b1;
        tick();
        rx_done_tick = 1'b0;
    endtask

    initial begin
        // Reset state and first edge after release
        tick();
        tick();
        chk("rst_outs", 32'(out_vec), 32'd0);
        chk("rst_outs0", 32'(z_out_vec), 32'd0);
        reset = 1'b1;
        chk("rx_en_pre", 32'(rx_en), 32'd0);
        tick();
        chk("rx_en_rel", 32'(rx_en), 32'd1);
        chk("ready_rel", 32'(cmd_ready), 32'd1);

        // Idle forwarding of a device byte
        rx_byte(8'h1C);
        chk("idle_kv", 32'(key_valid), 32'd1);
        chk("idle_kd", 32'(key_data), 32'h1C);
        chk("idle_busy", 32'(busy), 32'd0);
        tick();
        chk("idle_kv_end", 32'(key_valid), 32'd0);
        chk("idle_kd_hold", 32'(key_data), 32'h1C);

        // Normal command 0xED acknowledged with 0xFA
        base = n_tx;
        send_cmd(8'hED);
        chk("ed_start", 32'(tx_start), 32'd1);
        chk("ed_data", 32'(tx_data), 32'hED);
        chk("ed_ready", 32'(cmd_ready), 32'd0);
        chk("ed_rxen", 32'(rx_en), 32'd0);
        chk("ed_busy", 32'(busy), 32'd1);
        tick();
        chk("ed_start_end", 32'(tx_start), 32'd0);
        cmd_valid = 1'b1;
        cmd_data  = 8'hAA;
        rx_byte(8'h33);
        cmd_valid = 1'b0;
        chk("waittx_no_kv", 32'(key_valid), 32'd0);
        chk("waittx_no_start", 32'(tx_start), 32'd0);
        pulse_txdone();
        chk("wr_rxen", 32'(rx_en), 32'd1);
        rx_byte(8'hFA);
        chk("ed_ok", 32'(resp_ok), 32'd1);
        chk("ed_ok_nokv", 32'(key_valid), 32'd0);
        chk("ed_ok_busy", 32'(busy), 32'd0);
        chk("ed_data_kept", 32'(tx_data), 32'hED);
        chk("ed_kd_kept", 32'(key_data), 32'h1C);
        tick();
        chk("ed_ok_end", 32'(resp_ok), 32'd0);
        chk("ed_ntx", 32'(n_tx - base), 32'd1);

        // 0xFF answered with 0xFE three times
        do_reset();
        base  = n_tx;
        base0 = n_tx0;
        send_cmd(8'hFF);
        chk("ff_start", 32'(tx_start), 32'd1);
        chk("ff_data", 32'(tx_data), 32'hFF);
        for (int i = 0; i < 3; i++) begin
            tick();
            pulse_txdone();
            rx_byte(8'hFE);
            chk("ff_nokv", 32'(key_valid), 32'd0);
            if (i < 2) begin
                chk("ff_resend", 32'(tx_start), 32'd1);
                chk("ff_nofail", 32'(resp_fail), 32'd0);
            end else begin
                chk("ff_fail", 32'(resp_fail), 32'd1);
                chk("ff_last_nostart", 32'(tx_start), 32'd0);
                chk("ff_idle", 32'(busy), 32'd0);
            end
            if (i == 0) chk("ff_fail0", 32'(z_resp_fail), 32'd1);
        end
        tick();
        chk("ff_fail_end", 32'(resp_fail), 32'd0);
        chk("ff_ntx", 32'(n_tx - base), 32'd3);
        chk("ff_ntx0", 32'(n_tx0 - base0), 32'd1);

        // Response timeout with a forwarded byte mid-wait, then 0x1C/0xFA
        do_reset();
        base0   = n_tx0;
        first_k = 0;
        send_cmd(8'hF4);
        tick();
        pulse_txdone();
        for (int k = 1; k <= 50; k++) begin
            if (k == 10) begin
                rx_data      = 8'h1C;
                rx_done_tick = 1'b1;
            end
            tick();
            rx_done_tick = 1'b0;
            if (k == 10) chk("to_fwd_kv", 32'(key_valid), 32'd1);
            if (tx_start && first_k == 0) first_k = k;
            if (k == 50) begin
                chk("to_fail0", 32'(z_resp_fail), 32'd1);
                chk("to_nostart0", 32'(z_tx_start), 32'd0);
            end
        end
        chk("to_cycle", 32'(first_k), 32'd50);
        chk("to_data", 32'(tx_data), 32'hF4);
        chk("to_ntx0", 32'(n_tx0 - base0), 32'd1);
        tick();
        pulse_txdone();
        rx_byte(8'h1C);
        chk("mix_kv", 32'(key_valid), 32'd1);
        chk("mix_kd", 32'(key_data), 32'h1C);
        chk("mix_nook", 32'(resp_ok), 32'd0);
        rx_byte(8'hFA);
        chk("mix_ok", 32'(resp_ok), 32'd1);
        chk("mix_nokv", 32'(key_valid), 32'd0);
        chk("mix_kd_kept", 32'(key_data), 32'h1C);

        // Reset asserted while waiting on the tx unit
        tick();
        send_cmd(8'h12);
        tick();
        base = n_resp;
        reset = 1'b0;
        #1;
        chk("mid_rst_outs", 32'(out_vec), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        chk("mid_rel_ready", 32'(cmd_ready), 32'd1);
        chk("mid_rel_busy", 32'(busy), 32'd0);
        pulse_txdone();
        rx_byte(8'hFA);
        chk("mid_no_resp", 32'(n_resp - base), 32'd0);
        chk("mid_fa_fwd", 32'(key_data), 32'hFA);

        // Byte forward and command accept on the same edge, then tx_err resend
        tick();
        cmd_data     = 8'h34;
        cmd_valid    = 1'b1;
        rx_data      = 8'h55;
        rx_done_tick = 1'b1;
        tick();
        cmd_valid    = 1'b0;
        rx_done_tick = 1'b0;
        chk("both_kv", 32'(key_valid), 32'd1);
        chk("both_kd", 32'(key_data), 32'h55);
        chk("both_start", 32'(tx_start), 32'd1);
        tick();
        tx_err = 1'b1;
        tick();
        tx_err = 1'b0;
        chk("txerr_resend", 32'(tx_start), 32'd1);
        chk("txerr_data", 32'(tx_data), 32'h34);
        chk("txerr_fail0", 32'(z_resp_fail), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
